// File: rtl/if_fetch_unit_if.sv
// Memory-controller fetch port: level request with address,
// single-cycle done pulse carrying the instruction word.
interface if_fetch_unit_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_done;
   logic [31:0] mem_inst;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_done,
      input  mem_inst
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_done,
      output mem_inst
   );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, single outstanding fetch, BHT+BTB
// next-PC prediction and redirect on EX misprediction.
module if_fetch_unit #(
   parameter int          IDX_W    = 6,
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall_hold_i,
   input  logic                   branch_error_i,
   input  logic [31:0]            branch_target_i,
   input  logic                   upd_valid_i,
   input  logic [31:0]            upd_pc_i,
   input  logic                   upd_taken_i,
   input  logic [31:0]            upd_target_i,
   if_fetch_unit_if.master        mem,
   output logic [31:0]            pc_o,
   output logic [31:0]            inst_o,
   output logic                   predict_result_o,
   output logic [31:0]            next_pc_o,
   output logic                   stall_req_o
);

   localparam int N     = 2 ** IDX_W;
   localparam int TAG_W = 30 - IDX_W;

   typedef enum logic [1:0] {
      S_REQ,
      S_OUT,
      S_DROP
   } state_e;

   state_e state_q, state_d;

   logic [31:0] pc_q, pc_d;
   logic [31:0] fa_q, fa_d;
   logic [31:0] pco_q, pco_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] npc_q, npc_d;
   logic        pred_q, pred_d;
   logic        req_q, req_d;
   logic        stall_q, stall_d;

   logic [1:0]       bht_q [N];
   logic [1:0]       bht_d [N];
   logic [N-1:0]     btb_vld_q, btb_vld_d;
   logic [TAG_W-1:0] btb_tag_q [N];
   logic [31:0]      btb_tgt_q [N];

   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] uidx;
   logic             hit;
   logic             taken;
   logic [31:0]      pnext;
   logic             btb_we;

   assign idx  = pc_q[IDX_W+1:2];
   assign uidx = upd_pc_i[IDX_W+1:2];

   always_comb begin
      hit   = btb_vld_q[idx] && (btb_tag_q[idx] == pc_q[31:IDX_W+2]);
      taken = hit && bht_q[idx][1];
      pnext = taken ? btb_tgt_q[idx] : pc_q + 32'd4;
   end

   assign btb_we = upd_valid_i && upd_taken_i;

   always_comb begin
      bht_d     = bht_q;
      btb_vld_d = btb_vld_q;
      if (upd_valid_i) begin
         if (upd_taken_i) begin
            if (bht_q[uidx] != 2'b11) bht_d[uidx] = bht_q[uidx] + 2'b01;
            btb_vld_d[uidx] = 1'b1;
         end else begin
            if (bht_q[uidx] != 2'b00) bht_d[uidx] = bht_q[uidx] - 2'b01;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      fa_d    = fa_q;
      pco_d   = pco_q;
      inst_d  = inst_q;
      npc_d   = npc_q;
      pred_d  = pred_q;
      if (branch_error_i) begin
         // redirect wins over everything; an in-flight fetch must still finish
         pc_d   = branch_target_i;
         pco_d  = '0;
         inst_d = '0;
         npc_d  = '0;
         pred_d = 1'b0;
         unique case (state_q)
            S_REQ: begin
               if (mem.mem_done) begin
                  fa_d    = branch_target_i;
                  state_d = S_REQ;
               end else begin
                  state_d = S_DROP;
               end
            end
            S_OUT: begin
               fa_d    = branch_target_i;
               state_d = S_REQ;
            end
            S_DROP: state_d = S_DROP;
            default: state_d = S_REQ;
         endcase
      end else begin
         unique case (state_q)
            S_REQ: begin
               if (mem.mem_done) begin
                  pco_d   = pc_q;
                  inst_d  = mem.mem_inst;
                  pred_d  = taken;
                  npc_d   = pnext;
                  pc_d    = pnext;
                  state_d = S_OUT;
               end
            end
            S_OUT: begin
               if (!stall_hold_i) begin
                  pco_d   = '0;
                  inst_d  = '0;
                  npc_d   = '0;
                  pred_d  = 1'b0;
                  fa_d    = pc_q;
                  state_d = S_REQ;
               end
            end
            S_DROP: begin
               if (mem.mem_done) begin
                  fa_d    = pc_q;
                  state_d = S_REQ;
               end
            end
            default: state_d = S_REQ;
         endcase
      end
      req_d   = (state_d != S_OUT);
      stall_d = (state_d != S_OUT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_REQ;
         pc_q      <= PC_RESET;
         fa_q      <= PC_RESET;
         pco_q     <= '0;
         inst_q    <= '0;
         npc_q     <= '0;
         pred_q    <= 1'b0;
         req_q     <= 1'b1;
         stall_q   <= 1'b1;
         bht_q     <= '{default: 2'b01};
         btb_vld_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         fa_q      <= fa_d;
         pco_q     <= pco_d;
         inst_q    <= inst_d;
         npc_q     <= npc_d;
         pred_q    <= pred_d;
         req_q     <= req_d;
         stall_q   <= stall_d;
         bht_q     <= bht_d;
         btb_vld_q <= btb_vld_d;
      end
   end

   // tag/target are qualified by the valid bit, so they need no reset
   always_ff @(posedge clk) begin
      if (btb_we) begin
         btb_tag_q[uidx] <= upd_pc_i[31:IDX_W+2];
         btb_tgt_q[uidx] <= upd_target_i;
      end
   end

   assign mem.mem_req      = req_q;
   assign mem.mem_addr     = fa_q;
   assign pc_o             = pco_q;
   assign inst_o           = inst_q;
   assign predict_result_o = pred_q;
   assign next_pc_o        = npc_q;
   assign stall_req_o      = stall_q;

endmodule
